// File: rtl/mult_arbiter_if.sv
// Requester and shared-multiplier signals of the two-port multiplier arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mult_arbiter_if;
    logic        req_a;
    logic        req_b;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic [3:0]  mcand_a;
    logic [3:0]  mcand_b;
    logic        gnt_a;
    logic        gnt_b;
    logic        rsp_valid_a;
    logic        rsp_valid_b;
    logic [19:0] rsp_product;
    logic        rsp_err;
    logic        busy;
    logic        m_st;
    logic [15:0] m_mult;
    logic [3:0]  m_mcand;
    logic [19:0] m_product;
    logic        m_done;

    modport slave (
        input  req_a, req_b, mult_a, mult_b, mcand_a, mcand_b, m_product, m_done,
        output gnt_a, gnt_b, rsp_valid_a, rsp_valid_b, rsp_product, rsp_err, busy,
               m_st, m_mult, m_mcand
    );

    modport master (
        output req_a, req_b, mult_a, mult_b, mcand_a, mcand_b, m_product, m_done,
        input  gnt_a, gnt_b, rsp_valid_a, rsp_valid_b, rsp_product, rsp_err, busy,
               m_st, m_mult, m_mcand
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 16x4 sequential multiplier between two
// requesters, with a post-reset drain period and a completion timeout.
module mult_arbiter #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned FLUSH_CYC = 10
) (
    input logic           clk,
    input logic           rst,
    mult_arbiter_if.slave bus
);
    typedef enum logic [2:0] {StFlush, StIdle, StLaunch, StWait, StResp} state_e;

    localparam int unsigned CntMax = (TIMEOUT > FLUSH_CYC) ? TIMEOUT : FLUSH_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            ptr_b_q;
    logic            owner_b_q;
    logic [15:0]     op_mult_q;
    logic [3:0]      op_mcand_q;
    logic            m_st_q;
    logic            rsp_valid_a_q;
    logic            rsp_valid_b_q;
    logic [19:0]     rsp_product_q;
    logic            rsp_err_q;
    logic            gnt_a;
    logic            gnt_b;

    // The pointer only breaks ties; a lone request is always served.
    always_comb begin
        gnt_a = (state_q == StIdle) && bus.req_a && (!bus.req_b || !ptr_b_q);
        gnt_b = (state_q == StIdle) && bus.req_b && (!bus.req_a || ptr_b_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StFlush;
            cnt_q         <= '0;
            ptr_b_q       <= 1'b0;
            owner_b_q     <= 1'b0;
            op_mult_q     <= '0;
            op_mcand_q    <= '0;
            m_st_q        <= 1'b0;
            rsp_valid_a_q <= 1'b0;
            rsp_valid_b_q <= 1'b0;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            m_st_q        <= 1'b0;
            rsp_valid_a_q <= 1'b0;
            rsp_valid_b_q <= 1'b0;
            unique case (state_q)
                StFlush: begin
                    if (cnt_q == CntW'(FLUSH_CYC - 1)) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (gnt_a || gnt_b) begin
                        owner_b_q  <= gnt_b;
                        ptr_b_q    <= !gnt_b;
                        op_mult_q  <= gnt_b ? bus.mult_b : bus.mult_a;
                        op_mcand_q <= gnt_b ? bus.mcand_b : bus.mcand_a;
                        m_st_q     <= 1'b1;
                        state_q    <= StLaunch;
                    end
                end
                StLaunch: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (bus.m_done) begin
                        rsp_product_q <= bus.m_product;
                        rsp_err_q     <= 1'b0;
                        rsp_valid_a_q <= !owner_b_q;
                        rsp_valid_b_q <= owner_b_q;
                        state_q       <= StResp;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        rsp_product_q <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_valid_a_q <= !owner_b_q;
                        rsp_valid_b_q <= owner_b_q;
                        state_q       <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    // A timed-out multiplier may still be busy, so drain it again.
                    cnt_q   <= '0;
                    state_q <= rsp_err_q ? StFlush : StIdle;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StFlush;
                end
            endcase
        end
    end

    assign bus.gnt_a       = gnt_a;
    assign bus.gnt_b       = gnt_b;
    assign bus.rsp_valid_a = rsp_valid_a_q;
    assign bus.rsp_valid_b = rsp_valid_b_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.m_st        = m_st_q;
    assign bus.m_mult      = op_mult_q;
    assign bus.m_mcand     = op_mcand_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a 9-cycle sequential multiplier model.
module tb_mult_arbiter;
    localparam int Timeout = 16;
    localparam int Limit   = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mult_arbiter_if bus ();

    mult_arbiter #(
        .TIMEOUT   (Timeout),
        .FLUSH_CYC (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Multiplier model: m_done nine cycles after the m_st cycle.
    logic        m_active;
    logic [3:0]  m_cnt;
    logic [19:0] m_res;
    logic        m_hang = 1'b0;
    logic        m_force = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_cnt    <= 4'd0;
            m_res    <= 20'd0;
        end else if (bus.m_st) begin
            m_active <= 1'b1;
            m_cnt    <= 4'd8;
            m_res    <= {4'b0, bus.m_mult} * {16'b0, bus.m_mcand};
        end else if (m_active) begin
            if (m_cnt == 4'd0) m_active <= 1'b0;
            else m_cnt <= m_cnt - 4'd1;
        end
    end

    assign bus.m_done    = (m_active && (m_cnt == 4'd0) && !m_hang) || m_force;
    assign bus.m_product = m_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_m_st"}, 32'(bus.m_st), 32'd0);
        check({tag, "_gnt"}, 32'({bus.gnt_a, bus.gnt_b}), 32'd0);
        check({tag, "_rsp_valid"}, 32'({bus.rsp_valid_a, bus.rsp_valid_b}), 32'd0);
        check({tag, "_rsp_product"}, 32'(bus.rsp_product), 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, "_m_mult"}, 32'(bus.m_mult), 32'd0);
    endtask

    // Counts sample points until a grant shows; strobes seen meanwhile are strays.
    task automatic await_gnt(output bit who_b, output int n, output int stray);
        n = 0;
        stray = 0;
        #1;
        while (!(bus.gnt_a || bus.gnt_b) && n < Limit) begin
            if (bus.m_st || bus.rsp_valid_a || bus.rsp_valid_b) stray++;
            tick();
            n++;
        end
        check("gnt_seen", 32'(bus.gnt_a || bus.gnt_b), 32'd1);
        check("gnt_onehot", 32'(bus.gnt_a && bus.gnt_b), 32'd0);
        who_b = bus.gnt_b;
    endtask

    task automatic await_rsp(input bit who_b, output int n);
        int   other = 0;
        int   mst = 0;
        logic hit = 1'b0;
        n = 0;
        while (!hit && n < Limit) begin
            tick();
            n++;
            if (bus.m_st) mst++;
            if (who_b ? bus.rsp_valid_a : bus.rsp_valid_b) other++;
            hit = who_b ? bus.rsp_valid_b : bus.rsp_valid_a;
        end
        check("rsp_seen", 32'(hit), 32'd1);
        check("rsp_other_owner", 32'(other), 32'd0);
        check("m_st_pulses", 32'(mst), 32'd1);
    endtask

    task automatic run_op(input string tag, input bit who_b, input logic [15:0] mult,
                          input logic [19:0] prod, input logic err, input int lat);
        int n;
        await_rsp(who_b, n);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_product"}, 32'(bus.rsp_product), 32'(prod));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
        check({tag, "_m_mult_stable"}, 32'(bus.m_mult), 32'(mult));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit who;
        int n;
        int stray;

        bus.req_a = 1'b0;   bus.req_b = 1'b0;
        bus.mult_a = 16'h0; bus.mult_b = 16'h0;
        bus.mcand_a = 4'h0; bus.mcand_b = 4'h0;

        // Reset state, then a single A request through the flush period.
        @(posedge clk);
        #1;
        reset_checks("reset");
        tick();
        rst = 1'b0;
        bus.req_a = 1'b1; bus.mult_a = 16'h1234; bus.mcand_a = 4'h5;
        await_gnt(who, n, stray);
        check("t1_flush_cycles", 32'(n), 32'd10);
        check("t1_stray", 32'(stray), 32'd0);
        check("t1_who", 32'(who), 32'd0);
        run_op("t1", 1'b0, 16'h1234, 20'h05B04, 1'b0, 11);
        bus.req_a = 1'b0;
        tick();
        check("t1_rsp_one_cycle", 32'(bus.rsp_valid_a), 32'd0);
        check("t1_idle", 32'(bus.busy), 32'd0);

        // m_done outside WAIT must not produce a response.
        m_force = 1'b1;
        tick();
        m_force = 1'b0;
        check("stray_done_busy", 32'(bus.busy), 32'd0);
        check("stray_done_rsp", 32'({bus.rsp_valid_a, bus.rsp_valid_b}), 32'd0);
        tick();
        check("stray_done_rsp2", 32'({bus.rsp_valid_a, bus.rsp_valid_b}), 32'd0);

        // Simultaneous requests after reset: A first, then B; boundary operands.
        rst = 1'b1;
        tick();
        reset_checks("reset2");
        rst = 1'b0;
        bus.req_a = 1'b1; bus.mult_a = 16'h0000; bus.mcand_a = 4'h9;
        bus.req_b = 1'b1; bus.mult_b = 16'hFFFF; bus.mcand_b = 4'hF;
        await_gnt(who, n, stray);
        check("t3_flush_cycles", 32'(n), 32'd10);
        check("t3_first_a", 32'(who), 32'd0);
        run_op("t3a", 1'b0, 16'h0000, 20'h00000, 1'b0, 11);
        bus.req_a = 1'b0;
        await_gnt(who, n, stray);
        check("t3_then_b", 32'(who), 32'd1);
        check("t3_b_wait", 32'(n), 32'd1);
        run_op("t3b", 1'b1, 16'hFFFF, 20'hEFFF1, 1'b0, 11);
        bus.req_b = 1'b0;

        // Both held continuously: strict alternation, one grant per operation.
        bus.req_a = 1'b1; bus.mult_a = 16'h1234; bus.mcand_a = 4'h5;
        bus.req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            await_gnt(who, n, stray);
            check("alt_who", 32'(who), 32'(i % 2));
            check("alt_gap", 32'(n), 32'd1);
            if (who) run_op("alt_b", 1'b1, 16'hFFFF, 20'hEFFF1, 1'b0, 11);
            else run_op("alt_a", 1'b0, 16'h1234, 20'h05B04, 1'b0, 11);
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;

        // Timeout with m_done tied low, followed by a fresh flush.
        m_hang = 1'b1;
        bus.req_a = 1'b1;
        await_gnt(who, n, stray);
        check("to_who", 32'(who), 32'd0);
        run_op("to", 1'b0, 16'h1234, 20'h00000, 1'b1, Timeout + 2);
        bus.req_a = 1'b0;
        m_hang = 1'b0;
        tick();
        check("to_flush_busy", 32'(bus.busy), 32'd1);
        check("to_rsp_one_cycle", 32'(bus.rsp_valid_a), 32'd0);
        bus.req_b = 1'b1; bus.mult_b = 16'h0000; bus.mcand_b = 4'h9;
        await_gnt(who, n, stray);
        check("to_reflush_cycles", 32'(n), 32'd10);
        check("to_next_who", 32'(who), 32'd1);
        run_op("to_next", 1'b1, 16'h0000, 20'h00000, 1'b0, 11);
        bus.req_b = 1'b0;

        // Reset four cycles after m_st discards the operation.
        bus.req_a = 1'b1; bus.mult_a = 16'h0003; bus.mcand_a = 4'h7;
        await_gnt(who, n, stray);
        tick();
        check("mid_m_st", 32'(bus.m_st), 32'd1);
        bus.req_a = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        reset_checks("mid_reset");
        tick();
        rst = 1'b0;
        bus.req_a = 1'b1;
        await_gnt(who, n, stray);
        check("mid_flush_cycles", 32'(n), 32'd10);
        check("mid_no_rsp", 32'(stray), 32'd0);
        run_op("mid_next", 1'b0, 16'h0003, 20'h00015, 1'b0, 11);
        bus.req_a = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles before an operation is declared failed; the legal minimum is 10.
REQ-002 SHALL have parameter FLUSH_CYC, default 10, meaning the number of post-reset cycles spent letting the shared multiplier drain.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_a, req_b  input  1  operation request from requester A or B; held until granted.
REQ-007 mult_a, mult_b  input  16  multiplier operand from each requester.
REQ-008 mcand_a, mcand_b  input  4  multiplicand operand from each requester.
REQ-009 gnt_a, gnt_b  output  1  combinational accept; the request and operands are taken at the edge where req_x and gnt_x are both high.
REQ-010 rsp_valid_a, rsp_valid_b  output  1  one-cycle response strobe to the owning requester.
REQ-011 rsp_product  output  20  result; valid only while a rsp_valid_x is high.
REQ-012 rsp_err  output  1  timeout flag; valid only while a rsp_valid_x is high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 m_st  output  1  start pulse to the shared 16x4 sequential multiplier.
REQ-015 m_mult  output  16  operand to the multiplier; m_mcand  output  4  operand to the multiplier.
REQ-016 m_product  input  20  multiplier result; m_done  input  1  multiplier completion, high for one cycle.

Function
REQ-017 SHALL implement exactly five states: FLUSH, IDLE, LAUNCH, WAIT and RESP.
REQ-018 FLUSH: hold m_st=0 and all gnt_x=0 for FLUSH_CYC cycles, then go to IDLE.
REQ-019 IDLE: when any req_x is high, assert gnt_x for exactly one requester selected per REQ-020, latch its operands and owner id, and go to LAUNCH; otherwise stay in IDLE.
REQ-020 Arbitration: a lone request is granted directly; on a simultaneous request the round-robin pointer wins; after each grant the pointer moves to the other requester; the pointer favours A after reset.
REQ-021 m_mult and m_mcand SHALL be driven from the latched operands, stable from LAUNCH through RESP.
REQ-022 LAUNCH: assert m_st=1 for exactly one cycle, clear the wait counter, and go to WAIT.
REQ-023 WAIT: increment the wait counter each cycle.
REQ-024 WAIT exit on completion: when m_done=1, capture m_product into rsp_product, set rsp_err=0, and go to RESP.
REQ-025 WAIT exit on timeout: when the counter reaches TIMEOUT with m_done never seen, set rsp_product=0 and rsp_err=1, and go to RESP.
REQ-026 m_done observed outside WAIT SHALL be ignored.
REQ-027 RESP: assert rsp_valid for the owner only, for exactly one cycle; go to IDLE after a normal completion or to FLUSH after a timeout.
REQ-028 Nominal latency: grant at cycle g, m_st at g+1, m_done at g+10, rsp_valid at g+11, IDLE at g+12; the earliest next m_st is at g+13.
REQ-029 A request raised during busy SHALL wait and SHALL NOT be dropped; gnt_x SHALL be 0 outside IDLE.
REQ-030 The product width SHALL be 20 bits, full precision with no truncation: 0xFFFF*0xF = 0xEFFF1.

Reset
REQ-031 rst SHALL force asynchronously: state=FLUSH, flush counter=0, pointer=A, m_st=0, gnt_a/gnt_b=0, rsp_valid_a/b=0, rsp_product=0, rsp_err=0, busy=1, latched operands=0.
REQ-032 Reset mid-operation SHALL discard the in-flight operation with no response issued, and the FLUSH period SHALL elapse before the next grant.

Verification
REQ-033 After reset, req_a=1 with mult_a=0x1234 and mcand_a=0x5 SHALL produce no gnt_a for 10 cycles, then gnt_a, then rsp_valid_a with rsp_product=0x05B04 and rsp_err=0 exactly 11 cycles after the grant.
REQ-034 req_a and req_b raised in the same cycle and held SHALL be granted A first and then B; rsp_valid_b SHALL never coincide with rsp_valid_a.
REQ-035 mult_b=0xFFFF with mcand_b=0xF SHALL give rsp_product=0xEFFF1; mult=0x0000 with mcand=0x9 SHALL give 0x00000.
REQ-036 m_done tied low SHALL make rsp_valid fire TIMEOUT+1 cycles after m_st with rsp_err=1 and rsp_product=0, followed by FLUSH and busy=1.
REQ-037 rst pulsed 4 cycles after m_st SHALL produce no rsp_valid and 10 FLUSH cycles; the next operation SHALL return the correct product.
REQ-038 With req_a held continuously while busy, there SHALL be exactly one grant per operation, grants alternating A/B when both requesters are active, and no lost request.
